// File: rtl/baccarat_fsm.sv
// Baccarat game controller: sequences the six card-load strobes for the
// card datapath, applies the natural and third-card rules to the scores
// coming back, and lights the winner at the end of the deal.
module baccarat_fsm #(
    parameter int unsigned NATURAL_MIN  = 8,
    parameter int unsigned PLAYER_STAND = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       game_done
);

    typedef enum logic [3:0] {
        S_P1,
        S_D1,
        S_P2,
        S_D2,
        S_CHECK,
        S_P3,
        S_BANK,
        S_D3,
        S_DONE
    } state_t;

    localparam logic [3:0] NATURAL_LIMIT = 4'(NATURAL_MIN);
    localparam logic [3:0] STAND_LIMIT   = 4'(PLAYER_STAND);

    // Strobe order inside the vectors: pcard1, dcard1, pcard2, dcard2, pcard3, dcard3
    state_t     state;
    state_t     next_state;
    logic [5:0] strobe_reg;
    logic [5:0] next_strobe;
    logic       done_reg;
    logic       next_done;
    logic [3:0] third_value;
    logic       banker_draws;
    logic       natural;

    // Face cards and tens count as zero for the banker table; 0 means no card
    always_comb begin
        third_value = (pcard3 <= 4'd9) ? pcard3 : 4'd0;
    end

    // Two-card naturals end the deal; scores above 9 are treated as naturals so the game always finishes
    always_comb begin
        natural = (pscore >= NATURAL_LIMIT) || (dscore >= NATURAL_LIMIT) ||
                  (pscore > 4'd9) || (dscore > 4'd9);
    end

    // Banker third-card table, indexed by banker total and the player's third card value
    always_comb begin
        banker_draws = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
            4'd3:             banker_draws = (third_value != 4'd8);
            4'd4:             banker_draws = (third_value >= 4'd2) && (third_value <= 4'd7);
            4'd5:             banker_draws = (third_value >= 4'd4) && (third_value <= 4'd7);
            4'd6:             banker_draws = (third_value >= 4'd6) && (third_value <= 4'd7);
            default:          banker_draws = 1'b0;
        endcase
    end

    // Next-state decode for the deal sequence and the drawing rules
    always_comb begin
        next_state = state;
        case (state)
            S_P1:    next_state = S_D1;
            S_D1:    next_state = S_P2;
            S_P2:    next_state = S_D2;
            S_D2:    next_state = S_CHECK;
            S_CHECK: begin
                if (natural)
                    next_state = S_DONE;
                else if (pscore < STAND_LIMIT)
                    next_state = S_P3;
                else if (dscore <= 4'd5)
                    next_state = S_D3;
                else
                    next_state = S_DONE;
            end
            S_P3:    next_state = S_BANK;
            S_BANK:  next_state = banker_draws ? S_D3 : S_DONE;
            S_D3:    next_state = S_DONE;
            S_DONE:  next_state = S_DONE;
            default: next_state = S_P1;
        endcase
    end

    // Output decode of the upcoming state so the registered outputs line up with the state they belong to
    always_comb begin
        next_strobe = 6'b000000;
        next_done   = 1'b0;
        case (next_state)
            S_P1:    next_strobe = 6'b100000;
            S_D1:    next_strobe = 6'b010000;
            S_P2:    next_strobe = 6'b001000;
            S_D2:    next_strobe = 6'b000100;
            S_P3:    next_strobe = 6'b000010;
            S_D3:    next_strobe = 6'b000001;
            S_DONE:  next_done   = 1'b1;
            default: next_strobe = 6'b000000;
        endcase
    end

    // State and registered outputs; reset parks the game at the first player card
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_P1;
            strobe_reg <= 6'b100000;
            done_reg   <= 1'b0;
        end else begin
            state      <= next_state;
            strobe_reg <= next_strobe;
            done_reg   <= next_done;
        end
    end

    // Every output is held low while reset is asserted, even before the reset edge arrives
    assign load_pcard1      = reset & strobe_reg[5];
    assign load_dcard1      = reset & strobe_reg[4];
    assign load_pcard2      = reset & strobe_reg[3];
    assign load_dcard2      = reset & strobe_reg[2];
    assign load_pcard3      = reset & strobe_reg[1];
    assign load_dcard3      = reset & strobe_reg[0];
    assign game_done        = reset & done_reg;
    assign player_win_light = reset & done_reg & (pscore >= dscore);
    assign dealer_win_light = reset & done_reg & (dscore >= pscore);

endmodule

// File: tb/tb_baccarat_fsm.sv
// Directed self-checking bench for the baccarat controller; the bench plays
// the datapath by driving the scores each hand would produce.
module tb_baccarat_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] pscore = 4'd0;
    logic [3:0] dscore = 4'd0;
    logic [3:0] pcard3 = 4'd0;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light, game_done;
    logic [8:0] outs;

    int checks = 0;
    int errors = 0;

    // Expected output vectors, bit order {lp1, ld1, lp2, ld2, lp3, ld3, pwin, dwin, done}
    localparam logic [8:0] V_NONE  = 9'b000000000;
    localparam logic [8:0] V_P1    = 9'b100000000;
    localparam logic [8:0] V_D1    = 9'b010000000;
    localparam logic [8:0] V_P2    = 9'b001000000;
    localparam logic [8:0] V_D2    = 9'b000100000;
    localparam logic [8:0] V_P3    = 9'b000010000;
    localparam logic [8:0] V_D3    = 9'b000001000;
    localparam logic [8:0] V_PWIN  = 9'b000000101;
    localparam logic [8:0] V_DWIN  = 9'b000000011;
    localparam logic [8:0] V_TIE   = 9'b000000111;

    baccarat_fsm dut (
        .clock            (clock),
        .reset            (reset),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .game_done        (game_done)
    );

    assign outs = {load_pcard1, load_dcard1, load_pcard2, load_dcard2,
                   load_pcard3, load_dcard3, player_win_light, dealer_win_light, game_done};

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [8:0] observed, input logic [8:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] ps, input logic [3:0] ds, input logic [3:0] p3);
        pscore = ps;
        dscore = ds;
        pcard3 = p3;
    endtask

    // Two reset edges, then the four-card deal up to S_CHECK
    task automatic startGame(input string name);
        applyStimulus(4'd0, 4'd0, 4'd0);
        reset = 1'b0;
        tick();
        tick();
        checkOutput({name, ".reset"}, outs, V_NONE);
        reset = 1'b1;
        #1;
        checkOutput({name, ".p1"}, outs, V_P1);
        tick();
        checkOutput({name, ".d1"}, outs, V_D1);
        tick();
        checkOutput({name, ".p2"}, outs, V_P2);
        tick();
        checkOutput({name, ".d2"}, outs, V_D2);
        tick();
        checkOutput({name, ".check"}, outs, V_NONE);
    endtask

    initial begin
        $display("[TB] baccarat_fsm directed test starting");
        tick();

        // Natural for the player ends the deal with no third cards
        startGame("natural");
        applyStimulus(4'd8, 4'd3, 4'd0);
        tick();
        checkOutput("natural.done", outs, V_PWIN);
        tick();
        checkOutput("natural.hold", outs, V_PWIN);

        // Player draws an 8, banker on 3 stands
        startGame("bank_stand");
        applyStimulus(4'd4, 4'd3, 4'd0);
        tick();
        checkOutput("bank_stand.p3", outs, V_P3);
        applyStimulus(4'd2, 4'd3, 4'd8);
        tick();
        checkOutput("bank_stand.bank", outs, V_NONE);
        tick();
        checkOutput("bank_stand.done", outs, V_DWIN);

        // Player draws a queen (value 0), banker on 3 draws and reaches 8
        startGame("bank_draw");
        applyStimulus(4'd4, 4'd3, 4'd0);
        tick();
        checkOutput("bank_draw.p3", outs, V_P3);
        applyStimulus(4'd4, 4'd3, 4'd12);
        tick();
        checkOutput("bank_draw.bank", outs, V_NONE);
        tick();
        checkOutput("bank_draw.d3", outs, V_D3);
        applyStimulus(4'd4, 4'd8, 4'd12);
        tick();
        checkOutput("bank_draw.done", outs, V_DWIN);

        // Banker on 6 draws only against a player third card of 6 or 7
        startGame("bank6");
        applyStimulus(4'd5, 4'd6, 4'd0);
        tick();
        checkOutput("bank6.p3", outs, V_P3);
        applyStimulus(4'd1, 4'd6, 4'd6);
        tick();
        tick();
        checkOutput("bank6.d3", outs, V_D3);
        applyStimulus(4'd1, 4'd0, 4'd6);
        tick();
        checkOutput("bank6.done", outs, V_PWIN);

        // Player stands on 7, dealer on 5 draws to 9
        startGame("stand");
        applyStimulus(4'd7, 4'd5, 4'd0);
        tick();
        checkOutput("stand.d3", outs, V_D3);
        applyStimulus(4'd7, 4'd9, 4'd0);
        tick();
        checkOutput("stand.done", outs, V_DWIN);

        // Tie on 6: both stand, both lights held
        startGame("tie");
        applyStimulus(4'd6, 4'd6, 4'd0);
        tick();
        checkOutput("tie.done", outs, V_TIE);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("tie.hold", outs, V_TIE);
        end

        // Out-of-range player score is treated as a natural
        startGame("range");
        applyStimulus(4'd12, 4'd4, 4'd0);
        tick();
        checkOutput("range.done", outs, V_PWIN);

        // Reset dropped while in S_P3 silences outputs at once and restarts the deal
        startGame("midreset");
        applyStimulus(4'd3, 4'd2, 4'd0);
        tick();
        checkOutput("midreset.p3", outs, V_P3);
        reset = 1'b0;
        #1;
        checkOutput("midreset.low", outs, V_NONE);
        tick();
        checkOutput("midreset.edge", outs, V_NONE);
        reset = 1'b1;
        #1;
        checkOutput("midreset.p1", outs, V_P1);
        tick();
        checkOutput("midreset.d1", outs, V_D1);
        tick();
        checkOutput("midreset.p2", outs, V_P2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
